// File: rtl/fp_bolme_pkg.sv
// Shared single-precision FP definitions for the divider, the multiplier
// and later FP blocks: field widths, special encodings, control states.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_NORM   = 3'd3,
    ST_PACK   = 3'd4
  } state_e;

  // Signed infinity; used for divide-by-zero and overflow saturation.
  function automatic logic [31:0] signed_inf(input logic s);
    return {s, POS_INF[30:0]};
  endfunction

  // Signed zero; used for zero dividends and underflow flush.
  function automatic logic [31:0] signed_zero(input logic s);
    return {s, 31'b0};
  endfunction

endpackage

// File: rtl/fp_bolme_if.sv
// Operand/result bundle of the FP divider with its start/done handshake.
interface fp_bolme_if;
  logic        start_i;
  logic [31:0] x1_i;
  logic [31:0] x2_i;
  logic [31:0] sonuc_o;
  logic        done_o;
  logic        mesgul_o;
  logic        dz_o;
  logic        ovf_o;
  logic        unf_o;

  modport master (
    output start_i, x1_i, x2_i,
    input  sonuc_o, done_o, mesgul_o, dz_o, ovf_o, unf_o
  );

  modport slave (
    input  start_i, x1_i, x2_i,
    output sonuc_o, done_o, mesgul_o, dz_o, ovf_o, unf_o
  );
endinterface

// File: rtl/fp_bolme_mantis_bolucu.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
// Remainder is one bit wider than the divisor so the shifted remainder
// (always < 2*divisor) never loses its top bit.
module mantis_bolucu #(
  parameter int MAN_W = 23
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [MAN_W:0]   i_m1,
  input  logic [MAN_W:0]   i_m2,
  output logic [MAN_W+1:0] o_q,
  output logic             o_last
);

  localparam int W  = MAN_W + 2;
  localparam int CW = $clog2(W);

  logic [W-1:0]  r_rem;
  logic [MAN_W:0] r_m2;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;

  logic          w_ge;
  logic [W-1:0]  w_diff;

  assign w_ge   = (r_rem >= {1'b0, r_m2});
  assign w_diff = w_ge ? (r_rem - {1'b0, r_m2}) : r_rem;
  assign o_q    = r_q;
  assign o_last = (r_cnt == '0);

  // Load operands, then subtract-if-fits and shift once per step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rem <= '0;
      r_m2  <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= {1'b0, i_m1};
      r_m2  <= i_m2;
      r_q   <= '0;
      r_cnt <= CW'(W - 1);
    end else if (i_step) begin
      r_rem        <= {w_diff[W-2:0], 1'b0};
      r_q[r_cnt]   <= w_ge;
      r_cnt        <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fp_bolme.sv
// Sequential IEEE-754 single-precision divider, sonuc = x1 / x2.
// Unpack and special cases, 25-step restoring mantissa divide, normalise
// with truncation, range check, pack. Denormal inputs flush to zero.
module fp_bolme
  import fp_pkg::*;
#(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W,
  parameter int BIAS  = fp_pkg::BIAS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  fp_bolme_if.slave   bus
);

  localparam int SB = EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] C_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] C_EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] C_ONE  = EW'(1);
  localparam logic [EXP_W-1:0]     C_EALL = '1;

  state_e                r_state;
  state_e                w_next;
  logic [31:0]           r_x1;
  logic [31:0]           r_x2;
  logic                  r_sign;
  logic signed [EW-1:0]  r_exp;
  logic [31:0]           r_sonuc;
  logic                  r_done;
  logic                  r_dz;
  logic                  r_ovf;
  logic                  r_unf;

  logic [EXP_W-1:0]      w_e1;
  logic [EXP_W-1:0]      w_e2;
  logic [MAN_W-1:0]      w_f1;
  logic [MAN_W-1:0]      w_f2;
  logic                  w_sign;
  logic signed [EW-1:0]  w_e_unp;
  logic signed [EW-1:0]  w_e_n;
  logic [MAN_W-1:0]      w_man;
  logic [MAN_W+1:0]      w_q;
  logic                  w_last;
  logic                  w_load;
  logic                  w_step;
  logic                  w_pack_ld;
  logic [31:0]           w_res;
  logic                  w_dz;
  logic                  w_ovf;
  logic                  w_unf;

  assign w_e1    = r_x1[MAN_W +: EXP_W];
  assign w_e2    = r_x2[MAN_W +: EXP_W];
  assign w_f1    = r_x1[MAN_W-1:0];
  assign w_f2    = r_x2[MAN_W-1:0];
  assign w_sign  = r_x1[SB] ^ r_x2[SB];
  assign w_e_unp = $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + C_BIAS;

  // Quotient lies in (0.5, 2): a clear top bit means one more left shift.
  assign w_e_n   = w_q[MAN_W+1] ? r_exp : (r_exp - C_ONE);
  assign w_man   = w_q[MAN_W+1] ? w_q[MAN_W:1] : w_q[MAN_W-1:0];

  mantis_bolucu #(.MAN_W(MAN_W)) u_mantis (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_load (w_load),
    .i_step (w_step),
    .i_m1   ({1'b1, w_f1}),
    .i_m2   ({1'b1, w_f2}),
    .o_q    (w_q),
    .o_last (w_last)
  );

  // Next state, datapath strobes and the result to be packed.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_pack_ld = 1'b0;
    w_res     = '0;
    w_dz      = 1'b0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) w_next = ST_UNPACK;
      end
      ST_UNPACK: begin
        if (w_e1 == C_EALL || w_e2 == C_EALL) begin
          w_res     = QNAN;
          w_pack_ld = 1'b1;
          w_next    = ST_PACK;
        end else if (w_e2 == '0) begin
          w_res     = signed_inf(w_sign);
          w_dz      = 1'b1;
          w_pack_ld = 1'b1;
          w_next    = ST_PACK;
        end else if (w_e1 == '0) begin
          w_res     = signed_zero(w_sign);
          w_pack_ld = 1'b1;
          w_next    = ST_PACK;
        end else begin
          w_load    = 1'b1;
          w_next    = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        w_step = 1'b1;
        if (w_last) w_next = ST_NORM;
      end
      ST_NORM: begin
        w_pack_ld = 1'b1;
        w_next    = ST_PACK;
        if (!w_e_n[EW-1] && (w_e_n >= C_EMAX)) begin
          w_res = signed_inf(r_sign);
          w_ovf = 1'b1;
        end else if (w_e_n[EW-1] || (w_e_n == '0)) begin
          w_res = signed_zero(r_sign);
          w_unf = 1'b1;
        end else begin
          w_res = {r_sign, w_e_n[EXP_W-1:0], w_man};
        end
      end
      ST_PACK: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Operands are captured only when a start is accepted in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (r_state == ST_IDLE && bus.start_i) begin
      r_x1 <= bus.x1_i;
      r_x2 <= bus.x2_i;
    end
  end

  // Sign and biased exponent survive the divide for normalisation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
    end else if (w_load) begin
      r_sign <= w_sign;
      r_exp  <= w_e_unp;
    end
  end

  // Result and flags update together on entry to PACK and hold after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sonuc <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_pack_ld;
      if (w_pack_ld) begin
        r_sonuc <= w_res;
        r_dz    <= w_dz;
        r_ovf   <= w_ovf;
        r_unf   <= w_unf;
      end
    end
  end

  assign bus.sonuc_o  = r_sonuc;
  assign bus.done_o   = r_done;
  assign bus.mesgul_o = (r_state != ST_IDLE);
  assign bus.dz_o     = r_dz;
  assign bus.ovf_o    = r_ovf;
  assign bus.unf_o    = r_unf;

endmodule

// File: tb/tb_fp_bolme.sv
// Bench for the sequential FP divider: directed table, random operands
// against an arithmetic reference, start-ignore, mid-op reset, back-to-back.
module tb_fp_bolme;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_bolme_if bus ();

  fp_bolme dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  fl;   // {dz, ovf, unf}
    int          lat;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Quotient from exact integer division of the significands, truncated.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] fl);
    int ea, eb, e;
    logic s;
    longint n, d, q;
    logic [22:0] man;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fl = 3'b000;
    if (ea == 255 || eb == 255) begin
      r = 32'h7FC00000;
    end else if (eb == 0) begin
      r = {s, 8'hFF, 23'h0}; fl = 3'b100;
    end else if (ea == 0) begin
      r = {s, 31'h0};
    end else begin
      n = longint'({1'b1, a[22:0]}) * (longint'(1) << 24);
      d = longint'({1'b1, b[22:0]});
      q = n / d;
      e = ea - eb + 127;
      if (q >= (longint'(1) << 24)) man = 23'(q >> 1);
      else begin man = 23'(q); e = e - 1; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; fl = 3'b010;
      end else if (e <= 0) begin
        r = {s, 31'h0}; fl = 3'b001;
      end else begin
        r = {s, 8'(e), man};
      end
    end
  endfunction

  // One operation from IDLE: returns result, flags, done cycle (start edge = 0),
  // whether busy stayed high throughout, and whether the next cycle was idle
  // with the result held. Optionally pulses a foreign start at pulse_cyc.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_cyc,
                        output logic [31:0] r, output logic [2:0] fl, output int cyc,
                        output logic to, output logic bok, output logic iok);
    bus.x1_i = a; bus.x2_i = b; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = 1; to = 1'b0; bok = 1'b1;
    while (!bus.done_o && !to) begin
      if (!bus.mesgul_o) bok = 1'b0;
      if (cyc == pulse_cyc) begin
        bus.start_i = 1'b1; bus.x1_i = 32'h3F800000; bus.x2_i = 32'h40400000;
      end else begin
        bus.start_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 100) to = 1'b1;
    end
    if (!bus.mesgul_o) bok = 1'b0;
    r  = bus.sonuc_o;
    fl = {bus.dz_o, bus.ovf_o, bus.unf_o};
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    iok = !bus.mesgul_o && !bus.done_o && (bus.sonuc_o === r);
  endtask

  initial begin
    logic [31:0] r, ra, rb, er;
    logic [2:0]  fl, efl;
    int          cyc;
    logic        to, bok, iok, seen;
    int          k;
    int          dc[3];
    logic [31:0] br[3];
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    logic [31:0] pr[3];

    tv[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28};
    tv[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 28};
    tv[2]  = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 3'b000, 28};
    tv[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100, 2};
    tv[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, 3'b000, 2};
    tv[5]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b000, 2};
    tv[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b010, 28};
    tv[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 3'b001, 28};
    tv[8]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 3'b100, 2};
    tv[9]  = '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 2};
    tv[10] = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 3'b000, 2};
    tv[11] = '{32'h00000000, 32'h00000000, 32'h7F800000, 3'b100, 2};
    tv[12] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 3'b100, 2};
    tv[13] = '{32'hC0000000, 32'h3F000000, 32'hC0800000, 3'b000, 28};
    tv[14] = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 3'b000, 28};
    tv[15] = '{32'h00000001, 32'hC0000000, 32'h80000000, 3'b000, 2};
    tv[16] = '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 28};
    tv[17] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000, 28};

    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.x1_i = '0; bus.x2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sonuc", bus.sonuc_o, 32'h0);
    chk("reset_ctrl", {27'b0, bus.done_o, bus.mesgul_o, bus.dz_o, bus.ovf_o, bus.unf_o}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      run_op(tv[i].a, tv[i].b, -1, r, fl, cyc, to, bok, iok);
      chk($sformatf("vec%0d_result", i), r, tv[i].res);
      chk($sformatf("vec%0d_flags", i), {29'b0, fl}, {29'b0, tv[i].fl});
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(tv[i].lat));
      chk($sformatf("vec%0d_busy", i), {31'b0, bok}, 32'h1);
      chk($sformatf("vec%0d_idle_hold", i), {31'b0, iok}, 32'h1);
    end

    for (int i = 0; i < 120; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 9) == 0) ra[30:23] = 8'(($urandom_range(0, 1) == 0) ? 0 : 255);
      if ($urandom_range(0, 9) == 0) rb[30:23] = 8'(($urandom_range(0, 1) == 0) ? 0 : 255);
      if ($urandom_range(0, 2) == 0) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 3));
      ref_div(ra, rb, er, efl);
      run_op(ra, rb, -1, r, fl, cyc, to, bok, iok);
      chk($sformatf("rand%0d_%h_%h_result", i, ra, rb), r, er);
      chk($sformatf("rand%0d_flags", i), {29'b0, fl}, {29'b0, efl});
    end

    // Start pulse in the middle of a divide must not disturb it.
    run_op(32'h40C00000, 32'h40000000, 10, r, fl, cyc, to, bok, iok);
    chk("ignored_start_result", r, 32'h40400000);
    chk("ignored_start_latency", 32'(cyc), 32'd28);

    // Asynchronous reset at cycle 15 of an operation aborts it.
    bus.x1_i = 32'h3F800000; bus.x2_i = 32'h40400000; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_sonuc", bus.sonuc_o, 32'h0);
    chk("midreset_ctrl", {27'b0, bus.done_o, bus.mesgul_o, bus.dz_o, bus.ovf_o, bus.unf_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.mesgul_o) seen = 1'b1;
    end
    chk("midreset_no_done", {31'b0, seen}, 32'h0);
    run_op(32'h3F800000, 32'h40400000, -1, r, fl, cyc, to, bok, iok);
    chk("after_reset_result", r, 32'h3EAAAAAA);
    chk("after_reset_latency", 32'(cyc), 32'd28);

    // start held high: three back-to-back operations.
    pa[0] = 32'h40C00000; pb[0] = 32'h40000000; pr[0] = 32'h40400000;
    pa[1] = 32'h3F800000; pb[1] = 32'h40400000; pr[1] = 32'h3EAAAAAA;
    pa[2] = 32'hC0F00000; pb[2] = 32'h40200000; pr[2] = 32'hC0400000;
    bus.x1_i = pa[0]; bus.x2_i = pb[0]; bus.start_i = 1'b1;
    @(posedge clk); #1;
    cyc = 1; k = 0;
    while (k < 3 && cyc < 200) begin
      if (bus.done_o) begin
        dc[k] = cyc; br[k] = bus.sonuc_o;
        k++;
        if (k < 3) begin
          bus.x1_i = pa[k]; bus.x2_i = pb[k];
        end else begin
          bus.start_i = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start_i = 1'b0;
    chk("b2b_done_count", 32'(k), 32'd3);
    if (k == 3) begin
      chk("b2b_first_done", 32'(dc[0]), 32'd28);
      for (int i = 0; i < 3; i++) chk($sformatf("b2b%0d_result", i), br[i], pr[i]);
      chk("b2b_gap1", 32'(dc[1] - dc[0]), 32'd29);
      chk("b2b_gap2", 32'(dc[2] - dc[1]), 32'd29);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
